// File: rtl/chroma_resampler.sv
// Streaming planar MCU chroma resampler: passes Y through and averages Cb/Cr
// horizontally (4:2:2) or in 2x2 blocks (4:2:0) using one line of pair sums.
`timescale 1ns/1ps
module chroma_resampler #(
  parameter int DATA_WIDTH = 8,
  parameter int MCU_W      = 16,
  parameter int MCU_H      = 16,
  parameter int ROUND      = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  err_tlast,
  output logic                  busy
);

  localparam int CW   = $clog2(MCU_W);
  localparam int RW   = $clog2(MCU_H);
  localparam int LB_N = MCU_W / 2;
  localparam int LW   = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam int PW   = DATA_WIDTH + 1;
  localparam int SW   = DATA_WIDTH + 2;

  localparam logic [1:0] MODE_444 = 2'd0;
  localparam logic [1:0] MODE_422 = 2'd1;
  localparam logic [1:0] MODE_420 = 2'd2;
  localparam logic [1:0] PL_Y     = 2'd0;
  localparam logic [1:0] PL_CR    = 2'd2;
  localparam logic [CW-1:0] COL_LAST = CW'(MCU_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MCU_H - 1);

  logic [1:0]            r_plane;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic [1:0]            r_mode;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [PW-1:0]         r_line [LB_N];
  logic [DATA_WIDTH-1:0] r_odata;
  logic                  r_ovalid;
  logic                  r_olast;
  logic                  r_err;
  logic                  r_busy;

  logic                  w_first;
  logic                  w_last;
  logic [LW-1:0]         w_lidx;
  logic [1:0]            w_mode_in;
  logic                  w_prod;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [SW-1:0]         w_sum2;
  logic [SW-1:0]         w_sum4;
  logic [PW-1:0]         w_pair;
  logic [DATA_WIDTH-1:0] w_out;

  // Position decode of the current input beat
  always_comb begin
    w_first   = (r_plane == PL_Y) && (r_row == {RW{1'b0}}) && (r_col == {CW{1'b0}});
    w_last    = (r_plane == PL_CR) && (r_row == ROW_LAST) && (r_col == COL_LAST);
    w_lidx    = LW'(r_col >> 1);
    w_mode_in = (cfg_mode == 2'd3) ? MODE_420 : cfg_mode;
  end

  // Beat classification and averaging datapath
  always_comb begin
    w_sum2 = SW'(r_hold) + SW'(s_axis_tdata) + SW'(ROUND);
    w_sum4 = SW'(r_line[w_lidx]) + SW'(r_hold) + SW'(s_axis_tdata) + SW'(2 * ROUND);
    w_pair = PW'(r_hold) + PW'(s_axis_tdata);
    w_prod = 1'b1;
    w_out  = s_axis_tdata;
    if (r_plane == PL_Y) begin
      w_prod = 1'b1;
      w_out  = s_axis_tdata;
    end else begin
      case (r_mode)
        MODE_444: begin
          w_prod = 1'b1;
          w_out  = s_axis_tdata;
        end
        MODE_422: begin
          w_prod = r_col[0];
          w_out  = DATA_WIDTH'(w_sum2 >> 1);
        end
        default: begin
          w_prod = r_col[0] & r_row[0];
          w_out  = DATA_WIDTH'(w_sum4 >> 2);
        end
      endcase
    end
  end

  // Consuming beats never stall; producing beats need room in the output register
  always_comb begin
    if (areset) begin
      s_axis_tready = 1'b0;
    end else if (w_prod) begin
      s_axis_tready = !r_ovalid || m_axis_tready;
    end else begin
      s_axis_tready = 1'b1;
    end
    w_in_hs  = s_axis_tvalid && s_axis_tready;
    w_out_hs = r_ovalid && m_axis_tready;
  end

  // Plane/row/column counter and mode latch
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_plane <= PL_Y;
      r_row   <= {RW{1'b0}};
      r_col   <= {CW{1'b0}};
      r_mode  <= MODE_444;
    end else if (w_in_hs) begin
      if (w_first) begin
        r_mode <= w_mode_in;
      end
      if (r_col == COL_LAST) begin
        r_col <= {CW{1'b0}};
        if (r_row == ROW_LAST) begin
          r_row   <= {RW{1'b0}};
          r_plane <= (r_plane == PL_CR) ? PL_Y : r_plane + 2'd1;
        end else begin
          r_row <= r_row + {{(RW-1){1'b0}}, 1'b1};
        end
      end else begin
        r_col <= r_col + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Pair register and the even-row pair-sum line
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_hold <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < LB_N; i++) begin
        r_line[i] <= {PW{1'b0}};
      end
    end else if (w_in_hs && (r_plane != PL_Y)) begin
      if (!r_col[0]) begin
        r_hold <= s_axis_tdata;
      end else if ((r_mode != MODE_444) && (r_mode != MODE_422) && !r_row[0]) begin
        r_line[w_lidx] <= w_pair;
      end
    end
  end

  // Output register; a producing handshake reloads it even while draining
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_odata  <= {DATA_WIDTH{1'b0}};
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
    end else if (w_in_hs && w_prod) begin
      r_odata  <= w_out;
      r_ovalid <= 1'b1;
      r_olast  <= w_last;
    end else if (w_out_hs) begin
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
    end
  end

  // Framing error pulse and block-activity flag
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_err  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_err <= w_in_hs && (s_axis_tlast != w_last);
      if (w_in_hs) begin
        r_busy <= 1'b1;
      end else if (w_out_hs && r_olast) begin
        r_busy <= !w_first;
      end
    end
  end

  assign m_axis_tdata  = r_odata;
  assign m_axis_tvalid = r_ovalid;
  assign m_axis_tlast  = r_olast;
  assign err_tlast     = r_err;
  assign busy          = r_busy;

endmodule

// File: tb/tb_chroma_resampler.sv
// Scoreboard bench: two 4x4 instances (ROUND=1/0) sharing stimulus and one default 16x16 instance.
`timescale 1ns/1ps
module tb_chroma_resampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  int errors = 0;
  int checks = 0;

  // 4x4 pair
  logic       s_rst, s_tv, s_tl, s_mr;
  logic [1:0] s_cfg;
  logic [7:0] s_td;
  logic       s_trdy1, s_mv1, s_ml1, s_err1, s_busy1;
  logic       s_trdy0, s_mv0, s_ml0, s_err0, s_busy0;
  logic [7:0] s_md1, s_md0;
  // 16x16
  logic       b_rst, b_tv, b_tl, b_mr;
  logic [1:0] b_cfg;
  logic [7:0] b_td;
  logic       b_trdy, b_mv, b_ml, b_err, b_busy;
  logic [7:0] b_md;

  chroma_resampler #(.DATA_WIDTH(8), .MCU_W(4), .MCU_H(4), .ROUND(1)) u_s1 (
    .aclk(clk), .areset(s_rst), .cfg_mode(s_cfg),
    .s_axis_tdata(s_td), .s_axis_tvalid(s_tv), .s_axis_tready(s_trdy1), .s_axis_tlast(s_tl),
    .m_axis_tdata(s_md1), .m_axis_tvalid(s_mv1), .m_axis_tready(s_mr), .m_axis_tlast(s_ml1),
    .err_tlast(s_err1), .busy(s_busy1));

  chroma_resampler #(.DATA_WIDTH(8), .MCU_W(4), .MCU_H(4), .ROUND(0)) u_s0 (
    .aclk(clk), .areset(s_rst), .cfg_mode(s_cfg),
    .s_axis_tdata(s_td), .s_axis_tvalid(s_tv), .s_axis_tready(s_trdy0), .s_axis_tlast(s_tl),
    .m_axis_tdata(s_md0), .m_axis_tvalid(s_mv0), .m_axis_tready(s_mr), .m_axis_tlast(s_ml0),
    .err_tlast(s_err0), .busy(s_busy0));

  chroma_resampler u_big (
    .aclk(clk), .areset(b_rst), .cfg_mode(b_cfg),
    .s_axis_tdata(b_td), .s_axis_tvalid(b_tv), .s_axis_tready(b_trdy), .s_axis_tlast(b_tl),
    .m_axis_tdata(b_md), .m_axis_tvalid(b_mv), .m_axis_tready(b_mr), .m_axis_tlast(b_ml),
    .err_tlast(b_err), .busy(b_busy));

  exp_t q1[$];
  exp_t q0[$];
  exp_t qb[$];
  int   blk[768];

  int cnt1 = 0, len1 = 0, run1 = 0, errc1 = 0;
  int cnt0 = 0, len0 = 0, run0 = 0;
  int cntb = 0, lenb = 0, runb = 0, errb = 0;
  bit stall_en = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int which, input int d, input bit l);
    exp_t e;
    e.d = 8'(d);
    e.l = l;
    case (which)
      0:       q1.push_back(e);
      1:       q0.push_back(e);
      default: qb.push_back(e);
    endcase
  endtask

  // Reference: build full planes then downsample on the output grid
  task automatic push_block(input int which, input int w, input int h, input int mode, input int rnd);
    int tmp[$];
    int n, b, v;
    n = w * h;
    for (int i = 0; i < n; i++) tmp.push_back(blk[i]);
    for (int p = 1; p < 3; p++) begin
      b = p * n;
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
          if (mode == 0) begin
            tmp.push_back(blk[b + r*w + c]);
          end else if (mode == 1) begin
            if ((c % 2) == 0) begin
              v = (blk[b + r*w + c] + blk[b + r*w + c + 1] + rnd) / 2;
              tmp.push_back(v);
            end
          end else begin
            if ((c % 2) == 0 && (r % 2) == 0) begin
              v = (blk[b + r*w + c] + blk[b + r*w + c + 1] +
                   blk[b + (r+1)*w + c] + blk[b + (r+1)*w + c + 1] + 2*rnd) / 4;
              tmp.push_back(v);
            end
          end
        end
      end
    end
    for (int i = 0; i < tmp.size(); i++) push_exp(which, tmp[i], i == tmp.size() - 1);
  endtask

  // Small-instance monitors
  always @(negedge clk) begin : mon_s1
    exp_t e;
    if (!s_rst) begin
      if (s_err1) errc1++;
      if (s_mv1 && s_mr) begin
        if (q1.size() == 0) begin
          check("s1_unexpected_output", int'(s_md1), -1);
        end else begin
          e = q1.pop_front();
          check("s1_data", int'(s_md1), int'(e.d));
          check("s1_last", int'(s_ml1), int'(e.l));
        end
        cnt1++; run1++;
        if (s_ml1) begin len1 = run1; run1 = 0; end
      end
    end else begin
      run1 = 0;
    end
  end

  always @(negedge clk) begin : mon_s0
    exp_t e;
    if (!s_rst) begin
      if (s_mv0 && s_mr) begin
        if (q0.size() == 0) begin
          check("s0_unexpected_output", int'(s_md0), -1);
        end else begin
          e = q0.pop_front();
          check("s0_data", int'(s_md0), int'(e.d));
          check("s0_last", int'(s_ml0), int'(e.l));
        end
        cnt0++; run0++;
        if (s_ml0) begin len0 = run0; run0 = 0; end
      end
    end else begin
      run0 = 0;
    end
  end

  // Big-instance monitor with stall-stability check
  always @(negedge clk) begin : mon_b
    exp_t e;
    static bit prev_stall = 1'b0;
    static logic [7:0] prev_d = 8'd0;
    if (!b_rst) begin
      if (b_err) errb++;
      if (prev_stall) begin
        check("stall_valid_held", int'(b_mv), 1);
        check("stall_data_held", int'(b_md), int'(prev_d));
      end
      prev_stall = b_mv && !b_mr;
      prev_d = b_md;
      if (b_mv && b_mr) begin
        if (qb.size() == 0) begin
          check("b_unexpected_output", int'(b_md), -1);
        end else begin
          e = qb.pop_front();
          check("b_data", int'(b_md), int'(e.d));
          check("b_last", int'(b_ml), int'(e.l));
        end
        cntb++; runb++;
        if (b_ml) begin lenb = runb; runb = 0; end
      end
    end else begin
      runb = 0;
      prev_stall = 1'b0;
    end
  end

  // Output back-pressure: one stall cycle in three when enabled
  initial begin
    b_mr = 1'b1;
    forever begin
      @(posedge clk); #1;
      b_mr = stall_en ? ((cyc % 3) != 0) : 1'b1;
      cyc++;
    end
  end

  task automatic send_s(input int d, input bit last);
    int t = 0;
    s_td = 8'(d); s_tl = last; s_tv = 1'b1;
    @(negedge clk);
    while (!(s_trdy1 && s_trdy0) && t < 200) begin t++; @(negedge clk); end
    if (t >= 200) check("s_send_timeout", t, 0);
    @(posedge clk); #1;
    s_tv = 1'b0; s_tl = 1'b0;
  endtask

  task automatic send_b(input int d, input bit last);
    int t = 0;
    b_td = 8'(d); b_tl = last; b_tv = 1'b1;
    @(negedge clk);
    while (!b_trdy && t < 200) begin t++; @(negedge clk); end
    if (t >= 200) check("b_send_timeout", t, 0);
    @(posedge clk); #1;
    b_tv = 1'b0; b_tl = 1'b0;
  endtask

  task automatic drain_s();
    int t = 0;
    while ((q1.size() != 0 || q0.size() != 0) && t < 2000) begin t++; @(negedge clk); end
    if (t >= 2000) check("s_drain_timeout", q1.size() + q0.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    int t = 0;
    while (qb.size() != 0 && t < 5000) begin t++; @(negedge clk); end
    if (t >= 5000) check("b_drain_timeout", qb.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic reset_b();
    b_rst = 1'b1; b_tv = 1'b0; b_tl = 1'b0;
    qb.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_b_tvalid", int'(b_mv), 0);
    check("rst_b_tlast", int'(b_ml), 0);
    check("rst_b_tdata", int'(b_md), 0);
    check("rst_b_err", int'(b_err), 0);
    check("rst_b_busy", int'(b_busy), 0);
    check("rst_b_tready", int'(b_trdy), 0);
    @(posedge clk); #1;
    b_rst = 1'b0;
  endtask

  task automatic run_big(input int mode, input int seed, input int bad_beat,
                         input int sw_beat, input int sw_mode, input int rst_beat);
    for (int i = 0; i < 768; i++) blk[i] = (i * 37 + seed * 11 + 5) & 255;
    push_block(2, 16, 16, mode, 1);
    b_cfg = 2'(mode);
    for (int i = 0; i < 768; i++) begin
      if (i == rst_beat) begin
        reset_b();
        return;
      end
      if (i == sw_beat) b_cfg = 2'(sw_mode);
      send_b(blk[i], (i == 767) != (i == bad_beat));
      if (i == 10) check("busy_mid_block", int'(b_busy), 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, base0, ebase;
    int cb_hand[4];
    s_rst = 1'b1; s_tv = 1'b0; s_tl = 1'b0; s_mr = 1'b1; s_cfg = 2'd0; s_td = 8'd0;
    b_rst = 1'b1; b_tv = 1'b0; b_tl = 1'b0; b_cfg = 2'd0; b_td = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", int'(s_trdy1), 0);
    check("rst_s_tvalid", int'(s_mv1), 0);
    check("rst_s_tlast", int'(s_ml1), 0);
    check("rst_s_tdata", int'(s_md1), 0);
    check("rst_s_err", int'(s_err1), 0);
    check("rst_s_busy", int'(s_busy1), 0);
    check("rst_b_tready0", int'(b_trdy), 0);
    check("rst_b_tvalid0", int'(b_mv), 0);
    check("rst_b_busy0", int'(b_busy), 0);
    @(posedge clk); #1;
    s_rst = 1'b0; b_rst = 1'b0;

    // 4x4 mode 2 with hand-computed outputs
    for (int i = 0; i < 16; i++) begin
      blk[i] = i;
      blk[16 + i] = (i / 4) * 40 + (i % 4 + 1) * 10;
      blk[32 + i] = 255;
    end
    cb_hand[0] = 35; cb_hand[1] = 55; cb_hand[2] = 115; cb_hand[3] = 135;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) push_exp(w, i, 1'b0);
      for (int i = 0; i < 4; i++) push_exp(w, cb_hand[i], 1'b0);
      for (int i = 0; i < 4; i++) push_exp(w, 255, i == 3);
    end
    base = cnt1; base0 = cnt0;
    s_cfg = 2'd2;
    for (int i = 0; i < 48; i++) send_s(blk[i], i == 47);
    drain_s();
    check("t1_count", cnt1 - base, 24);
    check("t1_tlast_pos", len1, 24);
    check("t1_count_r0", cnt0 - base0, 24);
    check("t1_busy_idle", int'(s_busy1), 0);

    // 4x4 mode 1: Cb pairs (3,4) -> 4 rounded, 3 truncated
    for (int i = 0; i < 16; i++) begin
      blk[i] = i * 5;
      blk[16 + i] = ((i % 2) != 0) ? 4 : 3;
      blk[32 + i] = i * 15;
    end
    push_exp(0, 0, 1'b0); push_exp(1, 0, 1'b0);
    for (int i = 1; i < 16; i++) begin push_exp(0, i * 5, 1'b0); push_exp(1, i * 5, 1'b0); end
    for (int i = 0; i < 8; i++) begin push_exp(0, 4, 1'b0); push_exp(1, 3, 1'b0); end
    for (int i = 0; i < 8; i++) begin
      push_exp(0, (blk[32 + 2*i] + blk[33 + 2*i] + 1) / 2, i == 7);
      push_exp(1, (blk[32 + 2*i] + blk[33 + 2*i]) / 2, i == 7);
    end
    base = cnt1;
    s_cfg = 2'd1;
    for (int i = 0; i < 48; i++) send_s(blk[i], i == 47);
    drain_s();
    check("t2_count", cnt1 - base, 32);
    check("t2_tlast_pos", len1, 32);
    check("t2_tlast_pos_r0", len0, 32);

    // 4x4 mode 0: identity
    for (int i = 0; i < 48; i++) blk[i] = (i * 53 + 7) & 255;
    push_block(0, 4, 4, 0, 1);
    push_block(1, 4, 4, 0, 0);
    base = cnt1;
    s_cfg = 2'd0;
    for (int i = 0; i < 48; i++) send_s(blk[i], i == 47);
    drain_s();
    check("t3_count", cnt1 - base, 48);
    check("t3_tlast_pos", len1, 48);
    check("small_no_err", errc1, 0);

    // 16x16 mode 2 under 1-of-3 output stalls
    stall_en = 1'b1;
    base = cntb; ebase = errb;
    run_big(2, 1, -1, -1, 0, -1);
    drain_b();
    stall_en = 1'b0;
    check("t4_count", cntb - base, 384);
    check("t4_tlast_pos", lenb, 384);
    check("t4_no_err", errb - ebase, 0);
    check("t4_busy_idle", int'(b_busy), 0);

    // Spurious tlast on beat 100
    base = cntb; ebase = errb;
    run_big(2, 2, 100, -1, 0, -1);
    drain_b();
    check("t5_err_pulses", errb - ebase, 1);
    check("t5_count", cntb - base, 384);
    check("t5_tlast_pos", lenb, 384);

    // Mode change mid-block, next block back-to-back in 4:4:4
    base = cntb;
    run_big(2, 3, -1, 300, 0, -1);
    run_big(0, 4, -1, -1, 0, -1);
    drain_b();
    check("t6_count", cntb - base, 384 + 768);
    check("t6_tlast_pos", lenb, 768);

    // Reset mid-block, then a clean block
    run_big(2, 5, -1, -1, 0, 500);
    base = cntb; ebase = errb;
    run_big(2, 6, -1, -1, 0, -1);
    drain_b();
    check("t7_count", cntb - base, 384);
    check("t7_tlast_pos", lenb, 384);
    check("t7_no_err", errb - ebase, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
